// File: rtl/la_tiectrl.sv
// la_tiectrl: staggered tie-off release controller.
// Holds N groups of W-bit signals at logic 0 and releases them one at a time,
// in index order, with a programmable inter-group delay between releases.
// Optional feature macro: LA_TIECTRL_SEQDOWN_EN. When it is defined, hold
// retracts the released groups one at a time in reverse order instead of
// dropping them all on the next edge.
module la_tiectrl #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int CW   = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic           clk,
  input  logic           reset_i,
  input  logic           en_i,
  input  logic           hold_i,
  input  logic [CW-1:0]  delay_i,
  input  logic [N*W-1:0] in_i,
  output logic [N*W-1:0] z_o,
  output logic [N-1:0]   release_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2
`ifdef LA_TIECTRL_SEQDOWN_EN
    ,S_RETRACT = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    release_q, release_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // PROP is an implementation tag only; it selects no logic.
  if (PROP == "DEFAULT") begin : g_prop_default
  end else begin : g_prop_custom
  end

`ifdef LA_TIECTRL_SEQDOWN_EN
  logic [IW-1:0] top_idx;

  // Locate the highest released group; retraction clears it first.
  always_comb begin
    top_idx = '0;
    for (int g = 0; g < N; g++) begin
      if (release_q[g]) top_idx = IW'(g);
    end
  end
`endif

  // State, release flags, group index and delay counter registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      release_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      release_q <= release_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

  // Sequencing: load counter on start, count down, release one group per
  // expiry; hold takes priority over counting in every active state.
  always_comb begin
    state_d   = state_q;
    release_d = release_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!hold_i && en_i) begin
          cnt_d   = delay_i;
          idx_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (hold_i) begin
          idx_d = '0;
`ifdef LA_TIECTRL_SEQDOWN_EN
          cnt_d   = delay_i;
          state_d = S_RETRACT;
`else
          release_d = '0;
          state_d   = S_IDLE;
`endif
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          release_d[idx_q] = 1'b1;
          cnt_d            = delay_i;
          if (idx_q == IW'(N - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        if (hold_i) begin
          idx_d = '0;
`ifdef LA_TIECTRL_SEQDOWN_EN
          cnt_d   = delay_i;
          state_d = S_RETRACT;
`else
          release_d = '0;
          state_d   = S_IDLE;
`endif
        end
      end
`ifdef LA_TIECTRL_SEQDOWN_EN
      S_RETRACT: begin
        // Runs to completion regardless of hold or en once entered.
        if (release_q == '0) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          release_d[top_idx] = 1'b0;
          cnt_d              = delay_i;
          if (release_d == '0) state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d   = S_IDLE;
        release_d = '0;
        idx_d     = '0;
        cnt_d     = '0;
      end
    endcase
  end

  // Per-group gating: a tied group presents all zeros.
  for (genvar gi = 0; gi < N; gi++) begin : g_gate
    assign z_o[gi*W +: W] = release_q[gi] ? in_i[gi*W +: W] : '0;
  end

  assign release_o = release_q;
`ifdef LA_TIECTRL_SEQDOWN_EN
  assign busy_o = (state_q == S_WAIT) || (state_q == S_RETRACT);
`else
  assign busy_o = (state_q == S_WAIT);
`endif
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_la_tiectrl.sv
// Directed bench for la_tiectrl (N=4, W=8, CW=8, default build).
// Edge numbering: "edge 0" is the rising edge that samples en in IDLE.
module tb_la_tiectrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic           en_i = 1'b0;
  logic           hold_i = 1'b0;
  logic [CW-1:0]  delay_i = '0;
  logic [N*W-1:0] in_i = 32'hA5A5A5A5;
  logic [N*W-1:0] z_o;
  logic [N-1:0]   release_o;
  logic           busy_o;
  logic           done_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int busy_cycles;

  la_tiectrl #(.N(N), .W(W), .CW(CW), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .hold_i    (hold_i),
    .delay_i   (delay_i),
    .in_i      (in_i),
    .z_o       (z_o),
    .release_o (release_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_status(input string tag, input logic [3:0] rel, input logic bsy, input logic dn);
    check({tag, ".release"}, 32'(release_o), 32'(rel));
    check({tag, ".busy"},    32'(busy_o),    32'(bsy));
    check({tag, ".done"},    32'(done_o),    32'(dn));
  endtask

  initial begin
    // Reset state
    ticks(2);
    check_status("reset", 4'b0000, 1'b0, 1'b0);
    check("reset.z", z_o, 32'h0);
    reset_i = 1'b0;
    tick();

    // delay=2 ramp: releases after edges 3, 6, 9, 12
    delay_i = 8'd2;
    en_i    = 1'b1;
    tick();                                    // edge 0
    en_i    = 1'b0;
    check_status("d2.e0", 4'b0000, 1'b1, 1'b0);
    ticks(2);                                  // edge 2
    check_status("d2.e2", 4'b0000, 1'b1, 1'b0);
    check("d2.e2.z", z_o, 32'h0);
    tick();                                    // edge 3
    check_status("d2.e3", 4'b0001, 1'b1, 1'b0);
    check("d2.e3.z", z_o, 32'h000000A5);
    ticks(2);                                  // edge 5
    check_status("d2.e5", 4'b0001, 1'b1, 1'b0);
    tick();                                    // edge 6
    check_status("d2.e6", 4'b0011, 1'b1, 1'b0);
    ticks(3);                                  // edge 9
    check_status("d2.e9", 4'b0111, 1'b1, 1'b0);
    ticks(2);                                  // edge 11
    check_status("d2.e11", 4'b0111, 1'b1, 1'b0);
    tick();                                    // edge 12
    check_status("d2.e12", 4'b1111, 1'b0, 1'b1);
    check("d2.e12.z", z_o, 32'hA5A5A5A5);

    // DONE ignores en and delay changes
    en_i    = 1'b1;
    delay_i = 8'd7;
    tick();
    en_i    = 1'b0;
    tick();
    en_i    = 1'b1;
    tick();
    en_i    = 1'b0;
    check_status("done.ign", 4'b1111, 1'b0, 1'b1);

    // hold in DONE re-ties everything
    hold_i = 1'b1;
    tick();
    check_status("done.hold", 4'b0000, 1'b0, 1'b0);
    check("done.hold.z", z_o, 32'h0);

    // hold and en together in IDLE stay idle
    en_i = 1'b1;
    ticks(3);
    check_status("idle.hold_en", 4'b0000, 1'b0, 1'b0);
    hold_i = 1'b0;
    en_i   = 1'b0;
    tick();

    // delay=0: one group per edge, busy for exactly 4 cycles
    delay_i = 8'd0;
    en_i    = 1'b1;
    tick();                                    // edge 0
    en_i    = 1'b0;
    busy_cycles = int'(busy_o);
    tick();
    busy_cycles += int'(busy_o);
    check("d0.e1.release", 32'(release_o), 32'h1);
    tick();
    busy_cycles += int'(busy_o);
    check("d0.e2.release", 32'(release_o), 32'h3);
    tick();
    busy_cycles += int'(busy_o);
    check("d0.e3.release", 32'(release_o), 32'h7);
    tick();
    busy_cycles += int'(busy_o);
    check_status("d0.e4", 4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      busy_cycles += int'(busy_o);
    end
    check("d0.busy_cycles", 32'(busy_cycles), 32'd4);
    hold_i = 1'b1;
    tick();
    hold_i = 1'b0;
    check_status("d0.hold", 4'b0000, 1'b0, 1'b0);

    // delay=3, hold once release=0011 -> immediate re-tie
    delay_i = 8'd3;
    en_i    = 1'b1;
    tick();                                    // edge 0
    en_i    = 1'b0;
    ticks(4);                                  // edge 4
    check("d3.e4.release", 32'(release_o), 32'h1);
    ticks(4);                                  // edge 8
    check("d3.e8.release", 32'(release_o), 32'h3);
    hold_i = 1'b1;
    tick();
    hold_i = 1'b0;
    check_status("d3.hold", 4'b0000, 1'b0, 1'b0);
    check("d3.hold.z", z_o, 32'h0);
    ticks(4);
    check_status("d3.idle", 4'b0000, 1'b0, 1'b0);

    // reset mid-sequence at release=0111, then restart from group 0
    delay_i = 8'd0;
    en_i    = 1'b1;
    tick();
    en_i    = 1'b0;
    ticks(3);
    check("rst.pre.release", 32'(release_o), 32'h7);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_status("rst.mid", 4'b0000, 1'b0, 1'b0);
    delay_i = 8'd1;
    en_i    = 1'b1;
    tick();                                    // edge 0
    en_i    = 1'b0;
    ticks(2);                                  // edge 2
    check_status("rst.restart.e2", 4'b0001, 1'b1, 1'b0);
    ticks(2);                                  // edge 4
    check("rst.restart.e4", 32'(release_o), 32'h3);
    hold_i = 1'b1;
    tick();
    hold_i = 1'b0;

    // delay 5 -> 1 mid-WAIT: first step keeps 5, later steps use 1
    in_i    = 32'h12345678;
    delay_i = 8'd5;
    en_i    = 1'b1;
    tick();                                    // edge 0, cnt=5
    en_i    = 1'b0;
    delay_i = 8'd1;
    ticks(5);                                  // edge 5
    check("chg.e5.release", 32'(release_o), 32'h0);
    tick();                                    // edge 6
    check("chg.e6.release", 32'(release_o), 32'h1);
    check("chg.e6.z", z_o, 32'h00000078);
    tick();                                    // edge 7
    check("chg.e7.release", 32'(release_o), 32'h1);
    tick();                                    // edge 8
    check("chg.e8.release", 32'(release_o), 32'h3);
    check("chg.e8.z", z_o, 32'h00005678);
    hold_i = 1'b1;
    tick();
    hold_i = 1'b0;

    // delay=255: 256 cycles per step, no counter wrap
    delay_i = 8'd255;
    en_i    = 1'b1;
    tick();                                    // edge 0
    en_i    = 1'b0;
    ticks(255);                                // edge 255
    check_status("d255.e255", 4'b0000, 1'b1, 1'b0);
    tick();                                    // edge 256
    check("d255.e256.release", 32'(release_o), 32'h1);
    ticks(255);                                // edge 511
    check("d255.e511.release", 32'(release_o), 32'h1);
    tick();                                    // edge 512
    check("d255.e512.release", 32'(release_o), 32'h3);
    hold_i = 1'b1;
    tick();
    hold_i = 1'b0;
    check_status("d255.hold", 4'b0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
